serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder that sits directly downstream of the team's half-adder stage (AND for carry, XOR for sum). It consumes one bit of each operand per clock, LSB first, and keeps the running carry in a flip-flop. After WIDTH cycles it presents the registered sum and carry-out with a one-cycle completion pulse. It trades latency for area in narrow datapaths.

## Interface
- WIDTH, 8, operand and sum width in bits; must be at least 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to add; sampled only in IDLE and DONE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; S and CO are valid from this cycle on.
- S  output  WIDTH  sum, registered.
- CO  output  1  carry-out, registered.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: shifting one bit per cycle.
  - DONE: one-cycle completion.
- Transitions:
  - IDLE, start=1: go to RUN.
  - RUN, last bit processed: go to DONE.
  - DONE, start=1: go to RUN.
  - DONE, start=0: go to IDLE.
- Accept edge (IDLE or DONE with start=1):
  - load shift_a<=A and shift_b<=B.
  - clear carry<=0, cnt<=0, acc<=0.
  - S and CO keep their old values until the new DONE.
- Each RUN edge:
  - sum_bit = shift_a[0] ^ shift_b[0] ^ carry.
  - carry <= (a&b) | (carry&(a^b)).
  - acc <= {sum_bit, acc[WIDTH-1:1]}.
  - shift_a and shift_b shift right by one.
  - cnt <= cnt+1.
- Edge where cnt==WIDTH-1:
  - S <= {sum_bit, acc[WIDTH-1:1]}.
  - CO <= new carry.
  - state goes to DONE.
- start is ignored while in RUN. No queueing and no error flag.
- A and B may change freely after the accept edge.
- Arithmetic is unsigned modulo 2^WIDTH; CO is bit WIDTH of A+B.
- cnt width is $clog2(WIDTH). It never exceeds WIDTH-1 and never wraps.

## Timing
- Reset (synchronous, dominates every other input):
  - state=IDLE.
  - busy=0, done=0, S=0, CO=0.
  - carry=0, cnt=0, acc=0, shift registers=0.
- Reset asserted mid-RUN: the operation is aborted on that edge, with no done pulse. The first start after reset is accepted normally.
- Latency, with start accepted on edge k:
  - busy=1 after edges k through k+WIDTH-1.
  - On edge k+WIDTH: done=1, busy=0, S and CO updated.
  - done drops on edge k+WIDTH+1 unless a new operation completes there.
- Back-to-back: start=1 during the DONE cycle is accepted on edge k+WIDTH+1. Sustained throughput is then one result per WIDTH+1 cycles.
- busy and done are never high simultaneously.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package serial_adder_pkg holds:
  - state enum: IDLE, RUN, DONE.
  - default-width localparam.
- One sub-module, full_adder_bit (combinational):
  - built from two half-adder cells plus an OR.
  - inputs a, b, cin; outputs sum, cout.
  - instantiated once in the RUN datapath.
- Top level holds the FSM, the counter, the two operand shift registers, the carry flip-flop and the output registers.

## Test plan
All scenarios use WIDTH=8.
- 0x00+0x00, start pulsed one cycle → busy for 8 cycles; done on the 8th edge after accept; S=0x00, CO=0.
- 0x5A+0x3C → S=0x96, CO=0. Then 0xFF+0x01 → S=0x00, CO=1 (full carry ripple).
- 0xFF+0xFF → S=0xFE, CO=1. A and B are changed to 0x00 right after accept; the result must be unchanged.
- start held high in RUN with new operands 0x11/0x22 → ignored; the first result completes normally.
  - start=1 during the DONE cycle → a new operation is accepted; 0x11+0x22 gives S=0x33 after 8 more edges.
- rst asserted on the 4th RUN edge of 0x80+0x80:
  - next cycle: busy=0, done=0, S=0x00, CO=0.
  - no done pulse follows.
  - the next start with 0x80+0x80 gives S=0x00, CO=1.
- Random unsigned A/B, at least 1000 operations, checked against A+B → S and CO match; done pulses exactly once per accepted start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  // Operand width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Control states: waiting, shifting one bit per clock, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half-adder cells (XOR for sum, AND for
// carry) with their carries merged by an OR.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder combines the two operand bits.
  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  // Second half adder folds in the incoming carry.
  assign sum       = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  // Either half adder may generate the carry-out, never both.
  assign cout      = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit of each operand per clock, LSB first,
// with the running carry held in a flip-flop. A result and a one-cycle done
// pulse appear WIDTH edges after the start is accepted.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             accept;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_cout;

  // The single adder cell always looks at the current LSBs and stored carry.
  full_adder_bit u_fa (
    .a    (shift_a[0]),
    .b    (shift_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state decode; start only matters when no operation is in flight.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = (cnt == LAST_CNT);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand shifters, carry, accumulator and counter; results land in S/CO
  // only on the final bit so earlier results stay visible until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a <= '0;
      shift_b <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      S       <= '0;
      CO      <= 1'b0;
    end else if (accept) begin
      shift_a <= A;
      shift_b <= B;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
    end else if (state == RUN) begin
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      acc     <= {fa_sum, acc[WIDTH-1:1]};
      carry   <= fa_cout;
      if (last_bit) begin
        S  <= {fa_sum, acc[WIDTH-1:1]};
        CO <= fa_cout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Status flags are registered from the next state so they change on the
  // same edge as the state and never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) using a result scoreboard.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] S;
  logic       CO;

  logic [8:0] expQ[$];
  int total = 0;
  int bad = 0;
  int acceptCount = 0;
  int doneCount = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .CO    (CO)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Wait until the adder can accept, then pulse start for one cycle with the
  // given operands, optionally recording the expected result.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit expectResult);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("wait_idle_timeout", 1, 0);
    A = a;
    B = b;
    start = 1'b1;
    if (expectResult) begin
      expQ.push_back({1'b0, a} + {1'b0, b});
      acceptCount++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      checkOutput("busy_done_exclusive", {31'd0, busy & done}, 0);
      if (done) begin
        doneCount++;
        if (expQ.size() == 0) begin
          checkOutput("spurious_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sum", {24'd0, S}, {24'd0, e[7:0]});
          checkOutput("carry_out", {31'd0, CO}, {31'd0, e[8]});
        end
      end
    end
  end

  initial begin
    int guard;
    bit sawDone;
    logic [7:0] ra;
    logic [7:0] rb;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);
    checkOutput("reset_S", {24'd0, S}, 0);
    checkOutput("reset_CO", {31'd0, CO}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero operands with exact latency: busy after edges k..k+7, done after k+8.
    applyStimulus(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("lat_busy_%0d", i), {31'd0, busy}, 1);
      checkOutput($sformatf("lat_nodone_%0d", i), {31'd0, done}, 0);
      @(negedge clk);
    end
    checkOutput("lat_done", {31'd0, done}, 1);
    checkOutput("lat_busy_end", {31'd0, busy}, 0);
    @(negedge clk);
    checkOutput("done_drops", {31'd0, done}, 0);

    // Plain sum, then full carry ripple.
    applyStimulus(8'h5A, 8'h3C, 1'b1);
    applyStimulus(8'hFF, 8'h01, 1'b1);

    // Operands changed right after accept must not disturb the result.
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    A = 8'h00;
    B = 8'h00;

    // start held through RUN is ignored; it is taken in the DONE cycle.
    applyStimulus(8'h40, 8'h01, 1'b1);
    A = 8'h11;
    B = 8'h22;
    start = 1'b1;
    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("held_start_timeout", 1, 0);
    expQ.push_back(9'h033);
    acceptCount++;
    @(negedge clk);
    start = 1'b0;
    checkOutput("accept_in_done", {31'd0, busy}, 1);

    // Reset on the 4th RUN edge aborts the operation silently.
    applyStimulus(8'h80, 8'h80, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_done", {31'd0, done}, 0);
    checkOutput("abort_S", {24'd0, S}, 0);
    checkOutput("abort_CO", {31'd0, CO}, 0);
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", {31'd0, sawDone}, 0);
    applyStimulus(8'h80, 8'h80, 1'b1);

    // Random back-to-back traffic.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, 1'b1);
    end

    // Drain outstanding results.
    guard = 0;
    while (expQ.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("done_per_start", doneCount, acceptCount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
